// File: rtl/sram_1rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw_ctrl
// Description : Single-port SRAM macro controller. It zero-fills the macro
//               after reset, then serves in-order reads through a
//               credit-limited 3-entry response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 40,
    parameter int MASK_W = 10,
    parameter int DEPTH  = 2048
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam int                C_FIFO_DEPTH = 3;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;
    logic [1:0]        r_occ;
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic              r_inflight;
    logic [DATA_W-1:0] r_fifo [C_FIFO_DEPTH];

    logic              w_credit;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read in flight already owns a FIFO slot, so it is counted as a credit.
    assign w_credit   = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3;
    assign req_ready  = (r_state == ST_RUN) && w_credit;
    assign w_accept   = req_valid & req_ready;
    assign w_push     = r_inflight;
    assign w_pop      = resp_valid & resp_ready;
    assign resp_valid = (r_occ != 2'd0);
    assign resp_rdata = r_fifo[r_rd_ptr];
    assign init_done  = r_init_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + ADDR_W'(1);
                    if (r_init_cnt == C_LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // The sweep drives the macro whenever reset is low; reset gates it off.
    always_comb begin
        if (r_state == ST_INIT) begin
            mem_en    = ~reset;
            mem_wmode = 1'b1;
            mem_addr  = r_init_cnt;
            mem_wmask = '1;
            mem_wdata = '0;
        end else begin
            mem_en    = w_accept;
            mem_wmode = req_write;
            mem_addr  = req_addr;
            mem_wmask = req_wmask;
            mem_wdata = req_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_occ      <= 2'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept & ~req_write;
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_rdata;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_push && (r_occ == 2'd3)));

endmodule
`default_nettype wire

// File: doc/sram_1rw_ctrl.md
SRAM_1RW_CTRL -- requirements
Module: sram_1rw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, the word address width.
REQ-002 SHALL have parameter DATA_W, default 40, the data width in bits.
REQ-003 SHALL have parameter MASK_W, default 10, the write-mask width; each bit covers DATA_W/MASK_W data bits, and DATA_W SHALL be divisible by MASK_W.
REQ-004 SHALL have parameter DEPTH, default 2048, the word count swept by init.
REQ-005 SHALL have ports:
- clock  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid and req_ready are both high.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_wmask  input  MASK_W  per-nibble write enable.
- resp_valid  output  1  read data valid.
- resp_ready  input  1  response consumer ready.
- resp_rdata  output  DATA_W  read data.
- init_done  output  1  zero-fill sweep complete.
- mem_en  output  1  macro enable.
- mem_wmode  output  1  macro write mode.
- mem_addr  output  ADDR_W  macro address.
- mem_wmask  output  MASK_W  macro write mask.
- mem_wdata  output  DATA_W  macro write data.
- mem_rdata  input  DATA_W  macro read data, valid the cycle after a read enable.

Function
REQ-006 SHALL implement a two-state FSM: INIT (entered on reset) and RUN.
REQ-007 In INIT, each cycle SHALL drive mem_en=1, mem_wmode=1, mem_wmask all-ones, mem_wdata=0, mem_addr=init_cnt; init_cnt increments by 1 from 0.
REQ-008 SHALL move INIT->RUN on the cycle init_cnt==DEPTH-1 is written, so the sweep takes exactly DEPTH cycles; init_done=1 from the first RUN cycle onward.
REQ-009 In INIT, req_ready SHALL be 0.
REQ-010 In RUN, req_ready SHALL be 1 iff occ+inflight<3.
- occ = response-queue occupancy, 0..3.
- inflight = 1 if a read was accepted the previous cycle.
- req_ready SHALL NOT depend on req_valid, req_write or resp_ready.
REQ-011 In RUN, the mem_* outputs SHALL be combinational from the request:
- mem_en = req_valid & req_ready;
- mem_wmode = req_write;
- mem_addr = req_addr;
- mem_wmask = req_wmask;
- mem_wdata = req_wdata.
REQ-012 An accepted write SHALL produce no response.
REQ-013 A read accepted at cycle T SHALL set inflight for cycle T+1, and mem_rdata SHALL be pushed into a 3-entry FIFO at the end of cycle T+1.
REQ-014 resp_valid SHALL equal occ!=0, and resp_rdata SHALL be the FIFO head, giving a minimum read latency of 2 cycles (resp_valid high at T+2).
REQ-015 A pop occurs on resp_valid & resp_ready; a simultaneous push and pop SHALL leave occ unchanged and preserve order.
REQ-016 Back-to-back reads with resp_ready held high SHALL sustain one read per cycle.
REQ-017 The FIFO SHALL never overflow; the REQ-010 credit rule guarantees this, and pushing while occ==3 is a design error to be asserted.
REQ-018 Responses SHALL be returned in request order, and interleaved writes SHALL NOT reorder reads.
REQ-019 Read-after-write to the same address SHALL return the newly written nibbles, since the write reaches the macro the cycle before the read.

Reset
REQ-020 Asserting reset at any time, including mid-sweep or with reads in flight, SHALL asynchronously set:
- FSM=INIT, init_cnt=0, occ=0, inflight=0;
- resp_valid=0, init_done=0, req_ready=0;
- FIFO pointers to 0.
REQ-021 Outstanding responses SHALL be discarded on reset, and the zero-fill sweep SHALL restart from address 0 after reset deasserts.
REQ-022 During reset, mem_en SHALL be 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then count cycles until init_done -> exactly 2048 zero writes to addresses 0..2047, init_done high on cycle 2049, then a read of addr 0x7FF returns 0.
- Write addr 0x005, data 0xAB_CDEF_0123, mask 0x3FF; then read 0x005 -> resp_rdata=0xABCDEF0123 exactly 2 cycles after acceptance.
- Write addr 0x005, data 0xFF_FFFF_FFFF, mask 0x001; then read -> 0xABCDEF012F.
- resp_ready=0, then issue 5 reads -> exactly 3 accepted, req_ready=0 afterwards; release resp_ready -> the 3 responses arrive in order, then req_ready returns to 1.
- 100 back-to-back reads with resp_ready=1 -> req_ready stays 1, and 100 in-order responses arrive on consecutive cycles.
- Assert reset with 2 responses queued and 1 read in flight -> resp_valid falls immediately, no response appears after reset, and the sweep restarts at addr 0.
